sr_control_mc: RTL
==================

// Module: sr_control_mc
//
// PURPOSE
//  Multicycle control FSM for schoolRISCV; replaces the single-cycle decoder.
//  - Sequences FETCH/DECODE/EXEC/MEM/WB over one shared datapath.
//  - Adds loads/stores (lw/sw), jalr, req/ack memory handshakes, bus timeout, illegal-op trap
//    and a retired-instruction counter.
//  - Decodes from the latched instruction register, so cmdOp/F3/F7 are stable from DECODE on.
//
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting for imem_ack/dmem_ack before TRAP (>=1)
//  INSTRET_W       32  width of instret counter
//
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          reset, asynchronous, active-high
//  cmdOp       in   7          opcode of latched instruction
//  cmdF3       in   3          funct3 of latched instruction
//  cmdF7       in   7          funct7 of latched instruction
//  aluZero     in   1          ALU result == 0
//  aluSlt      in   1          ALU compare result (signed or unsigned per aluControl)
//  imem_req    out  1          instruction fetch request, held until imem_ack
//  imem_ack    in   1          fetch data valid this cycle
//  dmem_req    out  1          data access request, held until dmem_ack
//  dmem_we     out  1          1 = store, 0 = load; valid while dmem_req
//  dmem_ack    in   1          data access complete this cycle
//  irWrite     out  1          latch fetched word into instruction register
//  pcWrite     out  1          update PC with source pcSrc
//  pcSrc       out  2          `PC_PLUS_4 / `PC_IMMB / `PC_IMMJ / `PC_RS1_IMM (0..3)
//  regWrite    out  1          register-file write enable
//  aluSrc      out  1          0 = rs2, 1 = immediate
//  wdSrc       out  2          `SAVE_ALU_RES / `SAVE_IMM / `SAVE_NEXT_PC / `SAVE_MEM_DATA (0..3)
//  aluControl  out  3          ALU op, sr_cpu.svh encodings
//  retire      out  1          1-cycle pulse when an instruction commits
//  instret     out  INSTRET_W  count of retired instructions
//  trap        out  1          sticky halt flag
//  trap_cause  out  2          0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout
//
// BEHAVIOUR
//  Reset
//  - rst high: state=IDLE, wait counter=0, instret=0, trap=0, trap_cause=0.
//  - Decoded outputs (pcSrc, wdSrc, aluControl, aluSrc) default to 0.
//  - All other outputs are 0 in IDLE. Async assert aborts any operation mid-flight.
//
//  States
//  - IDLE -> FETCH, unconditional, next cycle.
//  - FETCH: imem_req=1.
//    - imem_ack: irWrite=1, -> DECODE.
//    - Else wait counter++. If it reaches TIMEOUT_CYCLES: -> TRAP, cause 2.
//  - DECODE: no enables. Supported ops: add, sub, or, srl, sltu, addi, lui, beq, bne, blt,
//    bge, bltu, bgeu, jal, jalr, lw, sw.
//    - Any other encoding: -> TRAP, cause 1.
//    - Else -> EXEC.
//  - EXEC: one cycle. Commit ops set pcWrite=1 and retire=1, then -> FETCH.
//    - R-type/addi/lui: regWrite=1; pcSrc=PLUS_4; aluControl and wdSrc as single-cycle decoder.
//    - Branch: pcSrc=IMMB if taken else PLUS_4.
//      - beq/bne: ALU_SUB, taken on aluZero / !aluZero.
//      - blt/bge: ALU_SLT; bltu/bgeu: ALU_SLTU; taken on aluSlt / !aluSlt.
//    - jal: regWrite=1, wdSrc=NEXT_PC, pcSrc=IMMJ.
//    - jalr: regWrite=1, wdSrc=NEXT_PC, aluSrc=1, ALU_ADD, pcSrc=RS1_IMM.
//    - lw/sw: aluSrc=1, ALU_ADD; no commit; -> MEM.
//  - MEM: dmem_req=1, dmem_we=(sw); aluSrc=1 and ALU_ADD held for the address.
//    - dmem_ack, sw: pcWrite=1, pcSrc=PLUS_4, retire=1, -> FETCH.
//    - dmem_ack, lw: -> WB.
//    - Timeout as in FETCH: -> TRAP, cause 3.
//  - WB: regWrite=1, wdSrc=SAVE_MEM_DATA, pcWrite=1, pcSrc=PLUS_4, retire=1, -> FETCH.
//  - TRAP: trap=1, all enables/reqs 0. Left only by reset.
//
//  Wait counter
//  - Cleared on entry to FETCH/MEM and on ack.
//  - Timeout checked before increment.
//  - ack on the same cycle as the count reaching the limit: ack wins.
//
//  Counting and pulses
//  - instret increments with retire and wraps modulo 2^INSTRET_W.
//  - Every enable/pulse is combinational from state + latched fields, and lasts exactly
//    one cycle per instruction.
//  - Latency: ALU/branch/jump = 3 cycles + imem wait; sw = 4 + waits; lw = 5 + waits.
//
// TESTING
//  1. Reset, imem_ack immediate, addi -> IDLE,FETCH,DECODE,EXEC; regWrite=1 and retire=1
//     in EXEC only; instret=1.
//  2. beq with aluZero=1 -> pcSrc=1, pcWrite=1; with aluZero=0 -> pcSrc=0; both retire.
//  3. lw with dmem_ack after 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has
//     wdSrc=3, regWrite=1.
//  4. imem_ack never arrives, TIMEOUT_CYCLES=4 -> TRAP after 4 wait cycles,
//     trap_cause=2; enables stay 0 until rst.
//  5. cmdOp=7'b0000000 -> TRAP from DECODE, trap_cause=1, instret unchanged.
//  6. rst asserted mid-MEM -> dmem_req drops same cycle; after release IDLE->FETCH,
//     instret=0.

Source files
------------

// File: rtl/sr_control_mc.sv
// sr_control_mc - multicycle control FSM for schoolRISCV.
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB over one shared datapath.
// It adds lw/sw, jalr, req/ack memory handshakes, a bus-wait timeout, an
// illegal-op trap and a retired-instruction counter. Decoding uses the
// latched instruction fields, so they are stable from DECODE onward.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_cmdOp/F3/F7         opcode/funct3/funct7 of the latched instruction
//   i_aluZero, i_aluSlt   ALU flags used for branch resolution
//   o_imem_req, i_imem_ack            instruction fetch handshake
//   o_dmem_req, o_dmem_we, i_dmem_ack data access handshake (we=1 store)
//   o_irWrite, o_pcWrite, o_pcSrc     IR / PC update controls
//   o_regWrite, o_aluSrc, o_wdSrc, o_aluControl  datapath controls
//   o_retire, o_instret   commit pulse and retired-instruction count
//   o_trap, o_trap_cause  sticky halt flag and its cause (1 ill, 2 imem, 3 dmem)
//
// States:
//   state    | meaning
//   S_IDLE   | after reset, no activity
//   S_FETCH  | imem request outstanding
//   S_DECODE | legality check of latched instruction
//   S_EXEC   | ALU/branch/jump commit, or address phase of lw/sw
//   S_MEM    | dmem request outstanding
//   S_WB     | load data written to register file
//   S_TRAP   | halted until reset

module sr_control_mc #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INSTRET_W      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_cmdOp,
  input  logic [2:0]           i_cmdF3,
  input  logic [6:0]           i_cmdF7,
  input  logic                 i_aluZero,
  input  logic                 i_aluSlt,
  output logic                 o_imem_req,
  input  logic                 i_imem_ack,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  input  logic                 i_dmem_ack,
  output logic                 o_irWrite,
  output logic                 o_pcWrite,
  output logic [1:0]           o_pcSrc,
  output logic                 o_regWrite,
  output logic                 o_aluSrc,
  output logic [1:0]           o_wdSrc,
  output logic [2:0]           o_aluControl,
  output logic                 o_retire,
  output logic [INSTRET_W-1:0] o_instret,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [1:0] PC_PLUS_4  = 2'd0;
  localparam logic [1:0] PC_IMMB    = 2'd1;
  localparam logic [1:0] PC_IMMJ    = 2'd2;
  localparam logic [1:0] PC_RS1_IMM = 2'd3;

  localparam logic [1:0] SAVE_ALU_RES  = 2'd0;
  localparam logic [1:0] SAVE_IMM      = 2'd1;
  localparam logic [1:0] SAVE_NEXT_PC  = 2'd2;
  localparam logic [1:0] SAVE_MEM_DATA = 2'd3;

  // Counter only has to reach TIMEOUT_CYCLES-1: the wait window is that many cycles.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_R, K_ADDI, K_LUI, K_BR, K_JAL, K_JALR, K_LW, K_SW
  } kind_t;

  state_t                 r_state;
  logic [CW-1:0]          r_wait_cnt;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   r_trap;
  logic [1:0]             r_trap_cause;

  kind_t      w_kind;
  logic [2:0] w_r_alu;
  logic [2:0] w_br_alu;
  logic       w_br_taken;
  logic       w_f7_zero;
  logic       w_f7_alt;

  assign w_f7_zero = (i_cmdF7 == 7'b0000000);
  assign w_f7_alt  = (i_cmdF7 == 7'b0100000);

  always_comb begin
    w_kind  = K_ILL;
    w_r_alu = ALU_ADD;
    case (i_cmdOp)
      OP_R: begin
        case (i_cmdF3)
          3'b000: begin
            if (w_f7_zero) begin
              w_kind = K_R; w_r_alu = ALU_ADD;
            end else if (w_f7_alt) begin
              w_kind = K_R; w_r_alu = ALU_SUB;
            end
          end
          3'b110: if (w_f7_zero) begin w_kind = K_R; w_r_alu = ALU_OR;   end
          3'b101: if (w_f7_zero) begin w_kind = K_R; w_r_alu = ALU_SRL;  end
          3'b011: if (w_f7_zero) begin w_kind = K_R; w_r_alu = ALU_SLTU; end
          default: w_kind = K_ILL;
        endcase
      end
      OP_IMM:    if (i_cmdF3 == 3'b000) w_kind = K_ADDI;
      OP_LUI:    w_kind = K_LUI;
      OP_BRANCH: if (i_cmdF3[2:1] != 2'b01) w_kind = K_BR;
      OP_JAL:    w_kind = K_JAL;
      OP_JALR:   if (i_cmdF3 == 3'b000) w_kind = K_JALR;
      OP_LOAD:   if (i_cmdF3 == 3'b010) w_kind = K_LW;
      OP_STORE:  if (i_cmdF3 == 3'b010) w_kind = K_SW;
      default:   w_kind = K_ILL;
    endcase
  end

  // funct3[2] selects compare vs equality; funct3[0] inverts the condition.
  assign w_br_alu   = !i_cmdF3[2] ? ALU_SUB : (i_cmdF3[1] ? ALU_SLTU : ALU_SLT);
  assign w_br_taken = (i_cmdF3[2] ? i_aluSlt : i_aluZero) ^ i_cmdF3[0];

  always_comb begin
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_irWrite    = 1'b0;
    o_pcWrite    = 1'b0;
    o_pcSrc      = PC_PLUS_4;
    o_regWrite   = 1'b0;
    o_aluSrc     = 1'b0;
    o_wdSrc      = SAVE_ALU_RES;
    o_aluControl = ALU_ADD;
    o_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_irWrite  = i_imem_ack;
      end
      S_EXEC: begin
        o_pcWrite = 1'b1;
        o_retire  = 1'b1;
        case (w_kind)
          K_R: begin
            o_regWrite   = 1'b1;
            o_aluControl = w_r_alu;
          end
          K_ADDI: begin
            o_regWrite = 1'b1;
            o_aluSrc   = 1'b1;
          end
          K_LUI: begin
            o_regWrite = 1'b1;
            o_wdSrc    = SAVE_IMM;
          end
          K_BR: begin
            o_aluControl = w_br_alu;
            o_pcSrc      = w_br_taken ? PC_IMMB : PC_PLUS_4;
          end
          K_JAL: begin
            o_regWrite = 1'b1;
            o_wdSrc    = SAVE_NEXT_PC;
            o_pcSrc    = PC_IMMJ;
          end
          K_JALR: begin
            o_regWrite = 1'b1;
            o_wdSrc    = SAVE_NEXT_PC;
            o_aluSrc   = 1'b1;
            o_pcSrc    = PC_RS1_IMM;
          end
          default: begin
            // lw/sw only compute the address here; commit happens later.
            o_pcWrite = 1'b0;
            o_retire  = 1'b0;
            o_aluSrc  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (w_kind == K_SW);
        o_aluSrc   = 1'b1;
        if (i_dmem_ack && (w_kind == K_SW)) begin
          o_pcWrite = 1'b1;
          o_retire  = 1'b1;
        end
      end
      S_WB: begin
        o_regWrite = 1'b1;
        o_wdSrc    = SAVE_MEM_DATA;
        o_pcWrite  = 1'b1;
        o_retire   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_instret    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'd0;
    end else begin
      if (o_retire) r_instret <= r_instret + INSTRET_W'(1);
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            r_wait_cnt <= '0;
            r_state    <= S_DECODE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 2'd2;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (w_kind == K_ILL) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 2'd1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait_cnt <= '0;
          r_state    <= ((w_kind == K_LW) || (w_kind == K_SW)) ? S_MEM : S_FETCH;
        end
        S_MEM: begin
          if (i_dmem_ack) begin
            r_wait_cnt <= '0;
            r_state    <= (w_kind == K_SW) ? S_FETCH : S_WB;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 2'd3;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_WB: begin
          r_wait_cnt <= '0;
          r_state    <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_instret    = r_instret;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_trap_cause;

endmodule
